traffic_phase_ctrl: RTL and testbench

Phase sequencer for a two-road intersection (main road, side road) with a side-road vehicle sensor and a latched pedestrian request. It is a Moore FSM with a shared phase timer that drives both light heads and the walk signal. Minimum green, maximum green, yellow and all-red clearance times are set by parameters. The block sits between the sensor inputs and the lamp drivers, and exposes its state code for debug and testbench monitoring.

---
 rtl/traffic_phase_ctrl.sv | 114 +++++++++++
 tb/tb_traffic_phase_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: Moore FSM with a shared saturating phase timer,
// driving main/side light heads and the pedestrian walk lamp.
module traffic_phase_ctrl #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int RED_CLR   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       car_side,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] state
);

    // state       | meaning
    // MAIN_GREEN  | main road green, waits for side car or pedestrian
    // MAIN_YELLOW | main road yellow
    // ALL_RED_A   | clearance before side green
    // SIDE_GREEN  | side road green, walk lamp on
    // SIDE_YELLOW | side road yellow
    // ALL_RED_B   | clearance before main green
    // BAD6, BAD7  | unused codes, recover to MAIN_GREEN
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'b000,
        MAIN_YELLOW = 3'b001,
        ALL_RED_A   = 3'b010,
        SIDE_GREEN  = 3'b011,
        SIDE_YELLOW = 3'b100,
        ALL_RED_B   = 3'b101,
        BAD6        = 3'b110,
        BAD7        = 3'b111
    } phase_t;

    localparam logic [7:0] GMIN_TC = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_TC = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_TC  = 8'(YELLOW_T - 1);
    localparam logic [7:0] RED_TC  = 8'(RED_CLR - 1);

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    phase_t     state_q;
    phase_t     state_d;
    logic [7:0] timer_q;
    logic       ped_pending_q;
    logic       ped_pending_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= MAIN_GREEN;
            timer_q       <= 8'd0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            if (state_d != state_q) begin
                timer_q <= 8'd0;
            end else if (timer_q != 8'hFF) begin
                timer_q <= timer_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (timer_q >= GMIN_TC && (car_side || ped_pending_q)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (timer_q == YEL_TC) state_d = ALL_RED_A;
            ALL_RED_A:   if (timer_q == RED_TC) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (timer_q == GMAX_TC || (timer_q >= GMIN_TC && !car_side)) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (timer_q == YEL_TC) state_d = ALL_RED_B;
            ALL_RED_B:   if (timer_q == RED_TC) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase
    end

    // The walk is granted by entering side green, so that edge consumes the request
    // even if a new one arrives on the same cycle.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q == ALL_RED_A && state_d == SIDE_GREEN) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && state_q != SIDE_GREEN) begin
            ped_pending_d = 1'b1;
        end
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        case (state_q)
            MAIN_GREEN:  main_light = LAMP_GREEN;
            MAIN_YELLOW: main_light = LAMP_YELLOW;
            SIDE_GREEN: begin
                side_light = LAMP_GREEN;
                walk       = 1'b1;
            end
            SIDE_YELLOW: side_light = LAMP_YELLOW;
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random traffic, checked against
// a phase-duration reference model.
module tb_traffic_phase_ctrl;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int RED_CLR   = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       car_side;
    logic       ped_req;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [2:0] state;

    int checks = 0;
    int fails  = 0;

    // Reference model: phase index, posedges spent in the phase, pending walk request.
    int m_phase = 0;
    int m_held  = 0;
    bit m_ped   = 1'b0;

    always #5 clock = ~clock;

    traffic_phase_ctrl #(
        .GREEN_MIN(GREEN_MIN),
        .GREEN_MAX(GREEN_MAX),
        .YELLOW_T (YELLOW_T),
        .RED_CLR  (RED_CLR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .car_side  (car_side),
        .ped_req   (ped_req),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .state     (state)
    );

    function automatic void model_edge(input bit c, input bit p, input bit r);
        bit leave;
        int dur;
        if (r) begin
            m_phase = 0;
            m_held  = 0;
            m_ped   = 1'b0;
            return;
        end
        dur = m_held + 1;
        case (m_phase)
            0:       leave = (dur >= GREEN_MIN) && (c || m_ped);
            1, 4:    leave = dur >= YELLOW_T;
            2, 5:    leave = dur >= RED_CLR;
            3:       leave = (dur >= GREEN_MAX) || (dur >= GREEN_MIN && !c);
            default: leave = 1'b1;
        endcase
        if (m_phase == 2 && leave) m_ped = 1'b0;
        else if (p && m_phase != 3) m_ped = 1'b1;
        if (leave) begin
            m_phase = (m_phase + 1) % 6;
            m_held  = 0;
        end else if (m_held < 255) begin
            m_held = m_held + 1;
        end
    endfunction

    function automatic logic [7:0] model_vec();
        logic [1:0] mn;
        logic [1:0] sd;
        mn = (m_phase == 0) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
        sd = (m_phase == 3) ? 2'b10 : (m_phase == 4) ? 2'b01 : 2'b00;
        return {3'(m_phase), mn, sd, (m_phase == 3)};
    endfunction

    task automatic cycle(input bit c, input bit p, input bit r);
        car_side = c;
        ped_req  = p;
        reset    = r;
        @(posedge clock);
        model_edge(c, p, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        checks++;
        if ({state, main_light, side_light, walk} !== 8'b000_10_00_0) begin
            fails++;
            $display("FAIL reset_values got=%b want=%b", {state, main_light, side_light, walk}, 8'b000_10_00_0);
        end
        for (int k = 0; k < 50; k++) begin
            cycle(0, 0, 0);
            checks++;
            if ({state, main_light, side_light, walk} !== 8'b000_10_00_0) begin
                fails++;
                $display("FAIL idle_hold k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, 8'b000_10_00_0);
            end
        end
    endtask

    task automatic test_car_side();
        int q[$];
        int runs[$];
        int cnt;
        int exp_runs[7] = '{4, 2, 1, 8, 2, 1, 4};
        cycle(1, 0, 1);
        q.push_back(int'(state));
        for (int k = 0; k < 36; k++) begin
            cycle(1, 0, 0);
            q.push_back(int'(state));
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL car_model k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, model_vec());
            end
            checks++;
            if (main_light !== 2'b00 && side_light !== 2'b00) begin
                fails++;
                $display("FAIL car_conflict k=%0d main=%b side=%b want one red", k, main_light, side_light);
            end
        end
        cnt = 1;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] == q[i-1]) cnt++;
            else begin
                runs.push_back(cnt);
                cnt = 1;
            end
        end
        checks++;
        if (runs.size() < 7) begin
            fails++;
            $display("FAIL car_runs_count got=%0d want>=7", runs.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (runs[i] != exp_runs[i]) begin
                    fails++;
                    $display("FAIL car_run_len idx=%0d got=%0d want=%0d", i, runs[i], exp_runs[i]);
                end
            end
        end
    endtask

    task automatic test_side_drop();
        int n;
        int k;
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        k = 0;
        while (state !== 3'd3 && k < 30) begin
            cycle(0, 0, 0);
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL drop_model k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, model_vec());
            end
            k++;
        end
        checks++;
        if (state !== 3'd3) begin
            fails++;
            $display("FAIL drop_reach_s3 got=%0d want=3", state);
        end
        n = 1;
        k = 0;
        while (state === 3'd3 && k < 20) begin
            cycle(k < 2, 0, 0);
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL drop_s3_model k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, model_vec());
            end
            if (state === 3'd3) n++;
            k++;
        end
        checks++;
        if (n != 4 || state !== 3'd4) begin
            fails++;
            $display("FAIL drop_s3_len got=%0d/next=%0d want=4/next=4", n, state);
        end
    endtask

    task automatic test_ped();
        int q[$];
        int runs[$];
        int cnt;
        int exp_runs[6] = '{4, 2, 1, 4, 2, 1};
        cycle(0, 0, 1);
        q.push_back(int'(state));
        for (int k = 0; k < 60; k++) begin
            cycle(0, k == 1, 0);
            q.push_back(int'(state));
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL ped_model k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, model_vec());
            end
        end
        cnt = 1;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] == q[i-1]) cnt++;
            else begin
                runs.push_back(cnt);
                cnt = 1;
            end
        end
        checks++;
        if (runs.size() != 6 || state !== 3'd0) begin
            fails++;
            $display("FAIL ped_single_pass runs=%0d final=%0d want runs=6 final=0", runs.size(), state);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (runs[i] != exp_runs[i]) begin
                    fails++;
                    $display("FAIL ped_run_len idx=%0d got=%0d want=%0d", i, runs[i], exp_runs[i]);
                end
            end
        end
    endtask

    task automatic test_ped_in_s4();
        int q[$];
        int runs[$];
        int cnt;
        bit seen;
        bit pulsed;
        bit p;
        int exp_runs[7] = '{4, 2, 1, 8, 2, 1, 4};
        seen   = 1'b0;
        pulsed = 1'b0;
        cycle(1, 0, 1);
        q.push_back(int'(state));
        for (int k = 0; k < 40; k++) begin
            if (state === 3'd4) seen = 1'b1;
            p = (state === 3'd4) && !pulsed;
            if (p) pulsed = 1'b1;
            cycle(!seen, p, 0);
            q.push_back(int'(state));
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL s4ped_model k=%0d got=%b want=%b", k, {state, main_light, side_light, walk}, model_vec());
            end
        end
        cnt = 1;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] == q[i-1]) cnt++;
            else begin
                runs.push_back(cnt);
                cnt = 1;
            end
        end
        checks++;
        if (runs.size() < 7) begin
            fails++;
            $display("FAIL s4ped_runs_count got=%0d want>=7", runs.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (runs[i] != exp_runs[i]) begin
                    fails++;
                    $display("FAIL s4ped_run_len idx=%0d got=%0d want=%0d", i, runs[i], exp_runs[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int n;
        cycle(1, 0, 1);
        k = 0;
        while (state !== 3'd3 && k < 30) begin
            cycle(1, 0, 0);
            k++;
        end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks++;
        if (state !== 3'd3) begin
            fails++;
            $display("FAIL rmid_setup got=%0d want=3", state);
        end
        cycle(1, 0, 1);
        checks++;
        if ({state, main_light, side_light, walk} !== 8'b000_10_00_0) begin
            fails++;
            $display("FAIL rmid_values got=%b want=%b", {state, main_light, side_light, walk}, 8'b000_10_00_0);
        end
        n = 1;
        k = 0;
        while (state === 3'd0 && k < 20) begin
            cycle(1, 0, 0);
            if (state === 3'd0) n++;
            k++;
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("FAIL rmid_timer_clear s0_len got=%0d want=4", n);
        end
        // pending request set in S1, then a reset edge that also carries ped_req
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        for (k = 0; k < 15; k++) begin
            cycle(0, 0, 0);
            checks++;
            if (state !== 3'd0 || state !== 3'(m_phase)) begin
                fails++;
                $display("FAIL rmid_pending_clear k=%0d got=%0d want=0", k, state);
            end
        end
    endtask

    task automatic test_random();
        bit c;
        bit p;
        bit r;
        c = 1'b0;
        cycle(0, 0, 1);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            p = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 99) == 0);
            cycle(c, p, r);
            checks++;
            if ({state, main_light, side_light, walk} !== model_vec()) begin
                fails++;
                $display("FAIL rand_model k=%0d c=%0b p=%0b r=%0b got=%b want=%b", k, c, p, r, {state, main_light, side_light, walk}, model_vec());
            end
            checks++;
            if (main_light !== 2'b00 && side_light !== 2'b00) begin
                fails++;
                $display("FAIL rand_conflict k=%0d main=%b side=%b want one red", k, main_light, side_light);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        car_side = 1'b0;
        ped_req  = 1'b0;
        test_reset();
        test_car_side();
        test_side_drop();
        test_ped();
        test_ped_in_s4();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
